// File: rtl/nor_cmd_sequencer_if.sv
// Host-side bus of the NOR command sequencer: write/read strobes, address,
// write data, read data return and the ready handshake.
interface nor_cmd_sequencer_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              host_we;
  logic              host_re;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              ready;

  modport master (
    output host_we, host_re, host_addr, host_wdata,
    input  host_rdata, host_rvalid, ready
  );

  modport slave (
    input  host_we, host_re, host_addr, host_wdata,
    output host_rdata, host_rvalid, ready
  );
endinterface

// File: rtl/nor_cmd_sequencer.sv
// JEDEC-style NOR unlock-sequence decoder turning host bus writes into single-cycle
// flash program/erase/read commands. Define NOR_SEQ_STATUS_EN to enable seq_err/err_cnt.
module nor_cmd_sequencer #(
  parameter logic [15:0] UNLOCK1_ADDR = 16'h0555,
  parameter logic [15:0] UNLOCK2_ADDR = 16'h02AA
) (
  input  logic                clk,
  input  logic                rst_n,
  nor_cmd_sequencer_if.slave  host,
  output logic [1:0]          f_cmd,
  output logic [15:0]         f_addr,
  output logic [7:0]          f_din,
  output logic                f_wr_en,
  input  logic [7:0]          f_dout,
  input  logic                f_busy,
  output logic                seq_err,
  output logic [7:0]          err_cnt
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_ERASE = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [DATA_W-1:0] D_UNLOCK1 = 8'hAA;
  localparam logic [DATA_W-1:0] D_UNLOCK2 = 8'h55;
  localparam logic [DATA_W-1:0] D_PROGRAM = 8'hA0;
  localparam logic [DATA_W-1:0] D_ERASE   = 8'h80;
  localparam logic [DATA_W-1:0] D_ERCONF  = 8'h30;
  localparam logic [DATA_W-1:0] D_RESET   = 8'hF0;

  typedef enum logic [3:0] {IDLE, U1, U2, PGM, E1, E2, E3, E4, ISSUE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              wr_en_nxt;
  logic              wr_acc, rd_acc, rd_pend;
  logic              hit1, hit2;

  assign host.ready      = (state != ISSUE) && !f_busy;
  assign host.host_rdata = f_dout;
  assign wr_acc = host.ready && host.host_we;
  assign rd_acc = host.ready && host.host_re && !host.host_we;
  assign hit1   = (host.host_addr == UNLOCK1_ADDR);
  assign hit2   = (host.host_addr == UNLOCK2_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and next values of the registered flash-side outputs.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = CMD_IDLE;
    addr_nxt  = f_addr;
    din_nxt   = f_din;
    wr_en_nxt = 1'b0;
    if (state == ISSUE) begin
      state_nxt = IDLE;
    end else if (wr_acc) begin
      if (host.host_wdata == D_RESET) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: if (hit1 && host.host_wdata == D_UNLOCK1) state_nxt = U1;
          U1:   state_nxt = (hit2 && host.host_wdata == D_UNLOCK2) ? U2 : IDLE;
          U2: begin
            if (hit1 && host.host_wdata == D_PROGRAM)    state_nxt = PGM;
            else if (hit1 && host.host_wdata == D_ERASE) state_nxt = E1;
            else                                         state_nxt = IDLE;
          end
          PGM: begin
            state_nxt = ISSUE;
            cmd_nxt   = CMD_WRITE;
            wr_en_nxt = 1'b1;
            addr_nxt  = host.host_addr;
            din_nxt   = host.host_wdata;
          end
          E1: state_nxt = (hit1 && host.host_wdata == D_UNLOCK1) ? E2 : IDLE;
          E2: state_nxt = (hit2 && host.host_wdata == D_UNLOCK2) ? E3 : IDLE;
          E3: begin
            if (host.host_wdata == D_ERCONF) begin
              state_nxt = ISSUE;
              cmd_nxt   = CMD_ERASE;
              addr_nxt  = host.host_addr;
            end else begin
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (rd_acc) begin
      cmd_nxt  = CMD_READ;
      addr_nxt = host.host_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_cmd            <= CMD_IDLE;
      f_addr           <= '0;
      f_din            <= '0;
      f_wr_en          <= 1'b0;
      rd_pend          <= 1'b0;
      host.host_rvalid <= 1'b0;
    end else begin
      f_cmd            <= cmd_nxt;
      f_addr           <= addr_nxt;
      f_din            <= din_nxt;
      f_wr_en          <= wr_en_nxt;
      rd_pend          <= rd_acc;
      host.host_rvalid <= rd_pend;
    end
  end

`ifdef NOR_SEQ_STATUS_EN
  // A mid-sequence write that falls back to IDLE without being F0 is an abort.
  logic err_hit;
  assign err_hit = wr_acc && (state inside {U1, U2, E1, E2, E3}) &&
                   (host.host_wdata != D_RESET) && (state_nxt == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      err_cnt <= '0;
    end else if (err_hit) begin
      seq_err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_nor_cmd_sequencer.sv
// Bench for nor_cmd_sequencer: sequence-matching reference model checked every cycle,
// plus directed literal checks for the program, erase, read, abort and reset cases.
module tb_nor_cmd_sequencer;
`ifdef NOR_SEQ_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  f_cmd;
  logic [15:0] f_addr;
  logic [7:0]  f_din, f_dout, err_cnt;
  logic        f_wr_en, f_busy, seq_err;

  nor_cmd_sequencer_if bus();

  nor_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .f_cmd(f_cmd), .f_addr(f_addr), .f_din(f_din), .f_wr_en(f_wr_en),
    .f_dout(f_dout), .f_busy(f_busy), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: match accepted writes against command patterns
  logic [15:0] pg_a [4] = '{16'h0555, 16'h02AA, 16'h0555, 16'h0000};
  logic [7:0]  pg_d [4] = '{8'hAA, 8'h55, 8'hA0, 8'h00};
  logic [15:0] er_a [6] = '{16'h0555, 16'h02AA, 16'h0555, 16'h0555, 16'h02AA, 16'h0000};
  logic [7:0]  er_d [6] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
  logic [15:0] h_a [$];
  logic [7:0]  h_d [$];

  logic [1:0]  m_cmd = 2'b00;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_din = '0, m_cnt = '0;
  logic        m_wren = 0, m_rv = 0, m_rdp = 0, m_err = 0, m_issue = 0, m_rdy;
  bit          started = 0;

  function automatic bit prefix_of(input bit erase);
    int n = h_a.size();
    if (n > (erase ? 6 : 4)) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (erase) begin
        if (i != 5 && h_a[i] != er_a[i]) return 1'b0;
        if (h_d[i] != er_d[i]) return 1'b0;
      end else if (i != 3) begin
        if (h_a[i] != pg_a[i] || h_d[i] != pg_d[i]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    bit p, e;
    if (d == 8'hF0) begin
      h_a.delete(); h_d.delete();
      return;
    end
    h_a.push_back(a); h_d.push_back(d);
    p = prefix_of(1'b0);
    e = prefix_of(1'b1);
    if (p && h_a.size() == 4) begin
      m_cmd = 2'b10; m_wren = 1'b1; m_addr = a; m_din = d; m_issue = 1'b1;
      h_a.delete(); h_d.delete();
    end else if (e && h_a.size() == 6) begin
      m_cmd = 2'b01; m_addr = a; m_issue = 1'b1;
      h_a.delete(); h_d.delete();
    end else if (!p && !e) begin
      if (h_a.size() > 1) begin
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      h_a.delete(); h_d.delete();
    end
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      m_cmd = 0; m_addr = 0; m_din = 0; m_wren = 0; m_rv = 0; m_rdp = 0;
      m_err = 0; m_cnt = 0; m_issue = 0;
      h_a.delete(); h_d.delete();
    end else begin
      m_rdy = !m_issue && !f_busy;
      m_rv = m_rdp; m_rdp = 0; m_cmd = 0; m_wren = 0; m_issue = 0;
      if (m_rdy && bus.host_we) model_write(bus.host_addr, bus.host_wdata);
      else if (m_rdy && bus.host_re) begin
        m_cmd = 2'b11; m_addr = bus.host_addr; m_rdp = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(bus.ready), 32'(!m_issue && !f_busy));
      chk("f_cmd", 32'(f_cmd), 32'(m_cmd));
      chk("f_addr", 32'(f_addr), 32'(m_addr));
      chk("f_din", 32'(f_din), 32'(m_din));
      chk("f_wr_en", 32'(f_wr_en), 32'(m_wren));
      chk("host_rvalid", 32'(bus.host_rvalid), 32'(m_rv));
      if (m_rv) chk("host_rdata", 32'(bus.host_rdata), 32'(f_dout));
      chk("seq_err", 32'(seq_err), 32'(STATUS ? m_err : 1'b0));
      chk("err_cnt", 32'(err_cnt), 32'(STATUS ? m_cnt : 8'h00));
    end
  end

  // ---------------- stimulus
  bit rnd = 0;

  task automatic cyc(input bit we, input bit re, input logic [15:0] a, input logic [7:0] d);
    bus.host_we = we; bus.host_re = re; bus.host_addr = a; bus.host_wdata = d;
    if (rnd) begin
      f_busy = ($urandom_range(0, 7) == 0);
      f_dout = 8'($urandom);
    end
    @(posedge clk); #1;
    bus.host_we = 1'b0; bus.host_re = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic rnd_wr(input logic [15:0] a, input logic [7:0] d);
    int r = $urandom_range(0, 19);
    logic [15:0] aa = a;
    logic [7:0]  dd = d;
    if (r == 0) dd = 8'hF0;
    else if (r == 1) dd = 8'($urandom);
    else if (r == 2) aa = 16'($urandom);
    cyc(1'b1, ($urandom_range(0, 9) == 0), aa, dd);
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; idle(); rst_n = 1'b1;
      end else begin
        cyc(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom), 8'h0);
      end
    end
  endtask

  initial begin
    bus.host_we = 0; bus.host_re = 0; bus.host_addr = 0; bus.host_wdata = 0;
    f_busy = 0; f_dout = 8'h00;

    idle(); idle();
    chk("rst f_cmd", 32'(f_cmd), 32'h0);
    chk("rst f_addr", 32'(f_addr), 32'h0);
    chk("rst ready", 32'(bus.ready), 32'h1);
    chk("rst err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;

    // program
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h55); wr(16'h0555, 8'hA0); wr(16'h0123, 8'h3C);
    chk("pgm f_cmd", 32'(f_cmd), 32'h2);
    chk("pgm f_wr_en", 32'(f_wr_en), 32'h1);
    chk("pgm f_addr", 32'(f_addr), 32'h0123);
    chk("pgm f_din", 32'(f_din), 32'h3C);
    chk("pgm ready", 32'(bus.ready), 32'h0);
    idle();
    chk("pgm after f_cmd", 32'(f_cmd), 32'h0);

    // erase
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h55); wr(16'h0555, 8'h80);
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h55); wr(16'h0140, 8'h30);
    chk("ers f_cmd", 32'(f_cmd), 32'h1);
    chk("ers f_addr", 32'(f_addr), 32'h0140);
    idle();

    // read
    f_dout = 8'h5A;
    cyc(1'b0, 1'b1, 16'h0123, 8'h00);
    chk("rd f_cmd", 32'(f_cmd), 32'h3);
    chk("rd f_addr", 32'(f_addr), 32'h0123);
    idle();
    chk("rd rvalid", 32'(bus.host_rvalid), 32'h1);
    chk("rd rdata", 32'(bus.host_rdata), 32'h5A);

    // bad unlock
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h56);
    chk("err f_cmd", 32'(f_cmd), 32'h0);
    chk("err seq_err", 32'(seq_err), 32'(STATUS));
    chk("err err_cnt", 32'(err_cnt), STATUS ? 32'h1 : 32'h0);

    // F0 abort then a clean program; same-cycle read is dropped
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h55); wr(16'h0000, 8'hF0);
    chk("f0 err_cnt", 32'(err_cnt), STATUS ? 32'h1 : 32'h0);
    cyc(1'b1, 1'b1, 16'h0555, 8'hAA);
    idle();
    chk("we+re rvalid", 32'(bus.host_rvalid), 32'h0);
    wr(16'h02AA, 8'h55); wr(16'h0555, 8'hA0); wr(16'h0200, 8'h11);
    chk("f0 pgm f_cmd", 32'(f_cmd), 32'h2);
    chk("f0 pgm f_addr", 32'(f_addr), 32'h0200);
    idle();

    // reset mid-sequence, then busy blocks strobes
    wr(16'h0555, 8'hAA); wr(16'h02AA, 8'h55); wr(16'h0555, 8'hA0);
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    chk("rst2 seq_err", 32'(seq_err), 32'h0);
    wr(16'h0123, 8'h00);
    chk("rst2 f_cmd", 32'(f_cmd), 32'h0);
    f_busy = 1'b1;
    bus.host_we = 1'b1; bus.host_addr = 16'h0555; bus.host_wdata = 8'hAA;
    #1 chk("busy ready", 32'(bus.ready), 32'h0);
    @(posedge clk); #1;
    bus.host_we = 1'b0; f_busy = 1'b0;
    wr(16'h02AA, 8'h55); wr(16'h0555, 8'hA0); wr(16'h0123, 8'h3C);
    chk("busy ignored f_cmd", 32'(f_cmd), 32'h0);
    idle();

    // randomized sequences
    rnd = 1;
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          rnd_wr(16'h0555, 8'hAA); rnd_wr(16'h02AA, 8'h55); rnd_wr(16'h0555, 8'hA0);
          rnd_wr(16'($urandom), 8'($urandom));
        end
        1: begin
          rnd_wr(16'h0555, 8'hAA); rnd_wr(16'h02AA, 8'h55); rnd_wr(16'h0555, 8'h80);
          rnd_wr(16'h0555, 8'hAA); rnd_wr(16'h02AA, 8'h55); rnd_wr(16'($urandom), 8'h30);
        end
        2: cyc(1'b0, 1'b1, 16'($urandom), 8'h0);
        default: cyc(1'b1, 1'b0, 16'($urandom), 8'($urandom));
      endcase
    end
    rnd = 0; f_busy = 1'b0;
    idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nor_cmd_sequencer.md
NOR_CMD_SEQUENCER -- requirements
Module: nor_cmd_sequencer

Interface
REQ-001 Parameter UNLOCK1_ADDR, default 16'h0555, first/third unlock-cycle address.
REQ-002 Parameter UNLOCK2_ADDR, default 16'h02AA, second unlock-cycle address.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 host_we  in  1  host bus write strobe, one cycle per bus write.
REQ-006 host_re  in  1  host read strobe.
REQ-007 host_addr  in  16  host address.
REQ-008 host_wdata  in  8  host write data (command byte or program data).
REQ-009 host_rdata  out  8  read data, combinational copy of f_dout.
REQ-010 host_rvalid  out  1  one-cycle pulse marking host_rdata valid.
REQ-011 ready  out  1  high when a host strobe will be accepted.
REQ-012 f_cmd  out  2  downstream flash command: 00 idle, 01 erase, 10 write, 11 read.
REQ-013 f_addr  out  16  downstream flash address.
REQ-014 f_din  out  8  downstream flash program data.
REQ-015 f_wr_en  out  1  downstream write enable.
REQ-016 f_dout  in  8  downstream flash read data.
REQ-017 f_busy  in  1  downstream busy.
REQ-018 seq_err  out  1  sticky unlock-sequence error flag.
REQ-019 err_cnt  out  8  saturating count of aborted sequences.

Function
REQ-020 All outputs to the flash SHALL be registered; f_cmd SHALL be non-zero for exactly one cycle per issued operation and 00 otherwise.
REQ-021 FSM states SHALL be IDLE, U1, U2, PGM, E1, E2, E3, E4, ISSUE.
REQ-022 IDLE: write (UNLOCK1_ADDR, AA) -> U1; U1: write (UNLOCK2_ADDR, 55) -> U2.
REQ-023 U2: (UNLOCK1_ADDR, A0) -> PGM; (UNLOCK1_ADDR, 80) -> E1.
REQ-024 PGM: any write -> ISSUE with f_cmd=10, f_wr_en=1, f_addr=host_addr, f_din=host_wdata; then IDLE.
REQ-025 Erase chain: E1 needs (UNLOCK1_ADDR, AA) -> E2; E2 needs (UNLOCK2_ADDR, 55) -> E3; E3 needs data 30 at any address -> ISSUE with f_cmd=01, f_addr=host_addr; then IDLE. E4 unused-reserved, never entered.
REQ-026 Write of data F0 in any state SHALL return to IDLE without issuing a flash command and without counting an error.
REQ-027 Any other write not matching the expected address/data SHALL return to IDLE, set seq_err, and increment err_cnt (saturating at 8'hFF).
REQ-028 Writes in IDLE not matching (UNLOCK1_ADDR, AA) or F0 SHALL be ignored silently, no error.
REQ-029 host_re accepted in any non-ISSUE state SHALL drive f_cmd=11, f_addr=host_addr for one cycle without changing FSM state; host_rvalid SHALL pulse exactly 2 cycles after the accepted host_re.
REQ-030 host_we and host_re in the same cycle: write accepted, read dropped, no rvalid.
REQ-031 ready SHALL be low in ISSUE and while f_busy=1; strobes while ready=0 SHALL be ignored entirely.
REQ-032 f_wr_en SHALL be high only together with f_cmd=10.

Reset
REQ-033 rst_n low SHALL force state IDLE, f_cmd=00, f_addr=0, f_din=0, f_wr_en=0, host_rvalid=0, seq_err=0, err_cnt=0, ready=1 at the next edge, including mid-sequence or mid-ISSUE.

Configuration
REQ-034 Macro NOR_SEQ_STATUS_EN defined: seq_err and err_cnt SHALL behave per REQ-027; undefined: both SHALL be constant 0 and error tracking logic absent, FSM behaviour unchanged.

Verification
REQ-035 Writes (555,AA),(2AA,55),(555,A0),(0123,3C) -> one cycle f_cmd=10, f_wr_en=1, f_addr=0123, f_din=3C; then f_cmd=00.
REQ-036 Writes (555,AA),(2AA,55),(555,80),(555,AA),(2AA,55),(0140,30) -> one cycle f_cmd=01, f_addr=0140.
REQ-037 host_re at addr 0123 in cycle N -> f_cmd=11 in cycle N+1, host_rvalid in cycle N+2 with host_rdata=f_dout.
REQ-038 (555,AA),(2AA,56) -> no flash command, state IDLE, seq_err=1, err_cnt=1 (0 if NOR_SEQ_STATUS_EN undefined).
REQ-039 (555,AA),(2AA,55),(0000,F0) then program sequence -> F0 aborts with no error; program issues normally.
REQ-040 rst_n low after (555,A0) step, then write (0123,00) -> no f_cmd=10 issued; f_busy=1 with host_we -> ready=0, write ignored.
